// File: rtl/foo_add_pkg.sv
// foo_add_pkg: shared constants, types and helpers for the foo_add_sched slice.
//   DEF_NUM_REQ / DEF_WIDTH : default requester count and operand width.
//   MAX_WIDTH / MAX_ID_W    : storage width of the stage structs; WIDTH must not
//                             exceed MAX_WIDTH and NUM_REQ must not exceed 16.
//   id_width()              : requester-ID width for a given requester count.
//   s0_t / s1_t             : operand stage and sum stage payloads.
package foo_add_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 32;
    localparam int MAX_WIDTH   = 64;
    localparam int MAX_ID_W    = 4;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Operands are held zero-extended to MAX_WIDTH; only the low WIDTH bits
    // of the sum are meaningful.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
        logic [MAX_ID_W-1:0]  id;
    } s0_t;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] sum;
        logic [MAX_ID_W-1:0]  id;
    } s1_t;

endpackage

// File: rtl/foo_rr_arbiter.sv
// foo_rr_arbiter: round-robin priority pick among NUM_REQ requests.
//   req   in  NUM_REQ  request vector
//   ptr   in  ID_W     index with highest priority this cycle
//   en    in  1        when low, no grant is produced
//   grant out NUM_REQ  one-hot grant (all-zero when nothing is granted)
//   idx   out ID_W     encoded index of the granted requester
module foo_rr_arbiter
    import foo_add_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    int unsigned     pos;
    logic [ID_W-1:0] cand;
    logic            found;

    // Walk the requesters starting at ptr, wrapping modulo NUM_REQ; the first
    // asserted request wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        cand  = '0;
        if (en) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                pos  = (32'(ptr) + k) % NUM_REQ;
                cand = ID_W'(pos);
                if (!found && req[cand]) begin
                    found       = 1'b1;
                    grant[cand] = 1'b1;
                    idx         = cand;
                end
            end
        end
    end

endmodule

// File: rtl/foo_add_sched.sv
// foo_add_sched: shares a two-stage add pipeline between NUM_REQ requesters.
//   clk, rst    in   clock and synchronous active-high reset
//   req_valid   in   NUM_REQ        per-requester request valid
//   req_ready   out  NUM_REQ        per-requester grant, at most one bit high
//   req_a/req_b in   NUM_REQ*WIDTH  packed operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid  out  1              result valid
//   resp_ready  in   1              downstream accepts result
//   resp_id     out  ID_W           requester that issued the result
//   resp_sum    out  WIDTH          a+b modulo 2^WIDTH
//   inflight    out  3              occupied pipeline slots, 0..2
module foo_add_sched
    import foo_add_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int WIDTH   = DEF_WIDTH,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_sum,
    output logic [2:0]               inflight
);

    s0_t             s0;
    s1_t             s1;
    logic            v0;
    logic            v1;
    logic [ID_W-1:0] ptr;

    logic            adv0;
    logic            adv1;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gidx;
    logic               accept;

    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    // S1 moves when empty or draining; S0 moves when empty or S1 moves.
    assign adv1 = !v1 || resp_ready;
    assign adv0 = !v0 || adv1;

    foo_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .en    (adv0 && !rst),
        .grant (grant),
        .idx   (gidx)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            v0  <= 1'b0;
            v1  <= 1'b0;
            ptr <= '0;
            s0  <= '0;
            s1  <= '0;
        end else begin
            if (adv1) begin
                s1.sum <= s0.a + s0.b;
                s1.id  <= s0.id;
                v1     <= v0;
            end
            if (adv0) begin
                if (accept) begin
                    s0.a  <= MAX_WIDTH'(a_arr[gidx]);
                    s0.b  <= MAX_WIDTH'(b_arr[gidx]);
                    s0.id <= MAX_ID_W'(gidx);
                    v0    <= 1'b1;
                    ptr   <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                end else begin
                    v0 <= 1'b0;
                end
            end
        end
    end

    assign resp_valid = v1;
    assign resp_id    = s1.id[ID_W-1:0];
    assign resp_sum   = s1.sum[WIDTH-1:0];
    assign inflight   = 3'(v0) + 3'(v1);

    // Upper storage bits only ever hold zero-extension and carries beyond WIDTH.
    logic unused_s1;
    assign unused_s1 = ^s1;

endmodule

// File: tb/tb_foo_add_sched.sv
module tb_foo_add_sched;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           resp_valid;
    logic           resp_ready;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_sum;
    logic [2:0]     inflight;

    foo_add_sched #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .inflight   (inflight)
    );

    always #5 clk = ~clk;

    // Reference: ordered list of in-flight transactions; the oldest becomes
    // visible at the output one edge after it was accepted.
    typedef struct {
        int         id;
        logic [31:0] sum;
        bit         visible;
    } item_t;

    item_t       q[$];
    int          ptr_m;
    int          last_g;
    int          grant_log[$];
    int          dut_ids[$];
    logic [31:0] dut_sums[$];
    bit          auto_drop;
    int          wait_acc[N];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]       = 1'b1;
        req_a[i*W +: W]    = a;
        req_b[i*W +: W]    = b;
    endtask

    // One clock: compare at negedge, advance the reference at posedge, then
    // release the granted requester if requesters drop after a grant.
    task automatic cycle();
        int          g;
        bit          vis;
        bit          pending;
        bit          stuck;
        bit          fire;
        logic [3:0]  exp_ready;
        logic [31:0] av;
        logic [31:0] bv;
        @(negedge clk);
        vis     = q.size() > 0 && q[0].visible;
        pending = q.size() > 0 && !q[q.size()-1].visible;
        stuck   = pending && vis && !resp_ready;
        g = -1;
        if (!rst && !stuck) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (ptr_m + k) % N;
                if (g < 0 && req_valid[j]) g = j;
            end
        end
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        fire = 1'b0;
        if (!rst) begin
            check("resp_valid", 64'(resp_valid), 64'(vis));
            check("inflight", 64'(inflight), 64'(q.size()));
            if (vis) begin
                check("resp_id", 64'(resp_id), 64'(q[0].id));
                check("resp_sum", 64'(resp_sum), 64'(q[0].sum));
            end
            fire = vis && resp_ready;
            if (resp_valid && resp_ready) begin
                dut_ids.push_back(int'(resp_id));
                dut_sums.push_back(resp_sum);
            end
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            ptr_m  = 0;
            last_g = -1;
            for (int i = 0; i < N; i++) wait_acc[i] = 0;
        end else begin
            if (fire) void'(q.pop_front());
            if (q.size() > 0 && !q[0].visible) q[0].visible = 1'b1;
            if (g >= 0) begin
                av = req_a[g*W +: W];
                bv = req_b[g*W +: W];
                q.push_back('{g, av + bv, 1'b0});
                ptr_m = (g + 1) % N;
                grant_log.push_back(g);
                for (int i = 0; i < N; i++)
                    if (i != g && req_valid[i]) wait_acc[i]++;
                check("starvation_bound", 64'(wait_acc[g] < N), 64'd1);
                wait_acc[g] = 0;
            end
            last_g = g;
        end
        #1;
        if (auto_drop && last_g >= 0) req_valid[last_g] = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    initial begin
        int acc;
        logic [1:0]  held_id;
        logic [31:0] held_sum;
        bit          got;
        int          exp_order[8];

        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        auto_drop  = 1'b1;
        ptr_m      = 0;
        last_g     = -1;

        // Reset state
        do_reset(2);
        check("reset_valid", 64'(resp_valid), 64'd0);
        check("reset_id", 64'(resp_id), 64'd0);
        check("reset_sum", 64'(resp_sum), 64'd0);
        check("reset_inflight", 64'(inflight), 64'd0);

        // Lone request from requester 2
        set_req(2, 32'h5, 32'h7);
        #1 check("single_grant", 64'(req_ready), 64'b0100);
        cycle();
        check("single_accept", 64'(last_g), 64'd2);
        check("single_infl_a", 64'(inflight), 64'd1);
        check("single_notyet", 64'(resp_valid), 64'd0);
        cycle();
        check("single_valid", 64'(resp_valid), 64'd1);
        check("single_id", 64'(resp_id), 64'd2);
        check("single_sum", 64'(resp_sum), 64'h0000000C);
        check("single_infl_b", 64'(inflight), 64'd1);
        cycle();
        check("single_infl_c", 64'(inflight), 64'd0);
        check("single_done", 64'(resp_valid), 64'd0);

        // Overflow wraps
        set_req(0, 32'hFFFFFFFF, 32'h2);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            cycle();
            got = resp_valid;
        end
        check("ovf_arrived", 64'(got), 64'd1);
        check("ovf_sum", 64'(resp_sum), 64'h00000001);
        check("ovf_id", 64'(resp_id), 64'd0);
        cycle();

        // Round-robin with all requesters held valid
        do_reset(1);
        auto_drop = 1'b0;
        grant_log.delete();
        dut_ids.delete();
        for (int i = 0; i < N; i++) set_req(i, 32'(i * 16 + 1), 32'(i));
        repeat (8) cycle();
        req_valid = '0;
        auto_drop = 1'b1;
        acc = 0;
        for (int i = 0; i < 8; i++) exp_order[i] = i % 4;
        check("rr_count", 64'(grant_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            check("rr_order", 64'(grant_log[i]), 64'(exp_order[i]));
        // First result visible in cycle 3, so 6 have drained after 8 cycles.
        check("rr_fires_8", 64'(dut_ids.size()), 64'd6);
        repeat (2) cycle();
        check("rr_fires_10", 64'(dut_ids.size()), 64'd8);
        for (int i = 0; i < 8 && i < dut_ids.size(); i++)
            check("rr_resp_order", 64'(dut_ids[i]), 64'(exp_order[i]));

        // Backpressure
        do_reset(1);
        resp_ready = 1'b0;
        set_req(0, 32'd10, 32'd20);
        set_req(1, 32'd30, 32'd40);
        acc = 0;
        held_id  = '0;
        held_sum = '0;
        for (int n = 0; n < 5; n++) begin
            cycle();
            if (last_g >= 0) acc++;
            if (n == 2) begin
                held_id  = resp_id;
                held_sum = resp_sum;
            end
        end
        check("bp_accepts", 64'(acc), 64'd2);
        check("bp_inflight", 64'(inflight), 64'd2);
        check("bp_ready_low", 64'(req_ready), 64'd0);
        check("bp_held_id", 64'(held_id), 64'd0);
        check("bp_held_sum", 64'(held_sum), 64'd30);
        check("bp_stable_id", 64'(resp_id), 64'(held_id));
        check("bp_stable_sum", 64'(resp_sum), 64'(held_sum));
        set_req(0, 32'd1, 32'd1);
        resp_ready = 1'b1;
        #1 check("bp_resume", 64'(req_ready), 64'b0001);
        dut_ids.delete();
        dut_sums.delete();
        repeat (4) cycle();
        check("bp_drained", 64'(dut_ids.size()), 64'd3);
        if (dut_ids.size() >= 3) begin
            check("bp_d0_id", 64'(dut_ids[0]), 64'd0);
            check("bp_d0_sum", 64'(dut_sums[0]), 64'd30);
            check("bp_d1_id", 64'(dut_ids[1]), 64'd1);
            check("bp_d1_sum", 64'(dut_sums[1]), 64'd70);
            check("bp_d2_id", 64'(dut_ids[2]), 64'd0);
            check("bp_d2_sum", 64'(dut_sums[2]), 64'd2);
        end

        // Bubble absorb: S1 stalled, S0 empty
        do_reset(1);
        resp_ready = 1'b0;
        set_req(3, 32'd100, 32'd1);
        cycle();
        check("bub_accept", 64'(last_g), 64'd3);
        cycle();
        check("bub_infl_1", 64'(inflight), 64'd1);
        check("bub_stalled", 64'(resp_valid), 64'd1);
        set_req(1, 32'd7, 32'd8);
        #1 check("bub_grant", 64'(req_ready), 64'b0010);
        cycle();
        check("bub_accept2", 64'(last_g), 64'd1);
        check("bub_infl_2", 64'(inflight), 64'd2);

        // Reset with two results in flight
        set_req(3, 32'd5, 32'd5);
        set_req(1, 32'd9, 32'd9);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_valid", 64'(resp_valid), 64'd0);
        check("rst_inflight", 64'(inflight), 64'd0);
        #1 check("rst_first_grant", 64'(req_ready), 64'b0010);
        resp_ready = 1'b1;
        dut_ids.delete();
        dut_sums.delete();
        repeat (5) cycle();
        check("rst_resp_count", 64'(dut_ids.size()), 64'd2);
        if (dut_ids.size() >= 2) begin
            check("rst_r0_id", 64'(dut_ids[0]), 64'd1);
            check("rst_r0_sum", 64'(dut_sums[0]), 64'd18);
            check("rst_r1_id", 64'(dut_ids[1]), 64'd3);
            check("rst_r1_sum", 64'(dut_sums[1]), 64'd10);
        end

        // Randomized traffic with backpressure and occasional reset
        for (int n = 0; n < 3000; n++) begin
            resp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 7) == 0)
                        set_req(i, 32'hFFFFFFFF, $urandom);
                    else
                        set_req(i, $urandom, $urandom);
                end
            end
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst        = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (4) cycle();
        check("final_empty", 64'(inflight), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
